// File: rtl/mppt_pwm.sv
// mppt_pwm: PWM generator whose duty is nudged by MPPT commands, applied only at period wrap.
// Optional soft-start ramp from DUTY_MIN to DUTY_INIT when MPPT_PWM_SOFTSTART_EN is defined.
module mppt_pwm #(
  parameter int PWM_W     = 10,
  parameter int STEP      = 4,
  parameter int DUTY_MIN  = 32,
  parameter int DUTY_MAX  = 992,
  parameter int DUTY_INIT = 512
)(
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       en,
  output logic             pwm,
  output logic [PWM_W-1:0] duty,
  output logic             busy,
  output logic             done,
  output logic             sat
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PEND = 2'd1;
`ifdef MPPT_PWM_SOFTSTART_EN
  localparam logic [1:0] RAMP = 2'd2;
`endif
  localparam logic [PWM_W:0]   STEP_X = (PWM_W+1)'(STEP);
  localparam logic [PWM_W:0]   MIN_X  = (PWM_W+1)'(DUTY_MIN);
  localparam logic [PWM_W:0]   MAX_X  = (PWM_W+1)'(DUTY_MAX);
  localparam logic [PWM_W:0]   INIT_X = (PWM_W+1)'(DUTY_INIT);
  localparam logic [PWM_W-1:0] MIN_D  = PWM_W'(DUTY_MIN);
  localparam logic [PWM_W-1:0] MAX_D  = PWM_W'(DUTY_MAX);
  localparam logic [PWM_W-1:0] INIT_D = PWM_W'(DUTY_INIT);
  logic [1:0]       state;
  logic [PWM_W-1:0] cnt, pend_duty, cmd_duty;
  logic [PWM_W:0]   duty_x, up_x, dn_x;
  logic             wrap, take;
  // one extra bit keeps up/down from wrapping before the clamp
  always_comb begin
    duty_x   = {1'b0, duty};
    up_x     = (duty_x + STEP_X > MAX_X) ? MAX_X : duty_x + STEP_X;
    dn_x     = (duty_x < MIN_X + STEP_X) ? MIN_X : duty_x - STEP_X;
    cmd_duty = en[1] ? up_x[PWM_W-1:0] : en[2] ? dn_x[PWM_W-1:0] : en[3] ? INIT_D : duty;
  end
`ifdef MPPT_PWM_SOFTSTART_EN
  logic [PWM_W:0] ramp_x;
  assign ramp_x = (duty_x + STEP_X > INIT_X) ? INIT_X : duty_x + STEP_X;
`endif
  assign wrap = &cnt;
  assign take = (state == IDLE) && (en != 4'd0) && ((en & (en - 4'd1)) == 4'd0);
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      pwm       <= 1'b0;
      done      <= 1'b0;
      sat       <= 1'b0;
      pend_duty <= INIT_D;
`ifdef MPPT_PWM_SOFTSTART_EN
      duty      <= MIN_D;
      state     <= RAMP;
`else
      duty      <= INIT_D;
      state     <= IDLE;
`endif
    end else begin
      cnt  <= cnt + 1'b1;
      pwm  <= cnt < duty;
      sat  <= (duty == MIN_D) || (duty == MAX_D);
      done <= 1'b0;
      if (take) begin
        pend_duty <= cmd_duty;
        state     <= PEND;
      end else if (state == PEND && wrap) begin
        duty  <= pend_duty;
        done  <= 1'b1;
        state <= IDLE;
      end
`ifdef MPPT_PWM_SOFTSTART_EN
      else if (state == RAMP && wrap) begin
        duty <= ramp_x[PWM_W-1:0];
        if (ramp_x == INIT_X) begin
          done  <= 1'b1;
          state <= IDLE;
        end
      end
`endif
    end
  end
endmodule
